// File: rtl/branch_target_predictor_if.sv
// Fetch-query, EX-resolution and statistics signals of the branch target predictor.
// The pipeline drives the master side; the predictor implements the slave side.
interface branch_target_predictor_if;
    logic [31:0] fetch_pc;
    logic        btb_hit;
    logic        br_pred;
    logic [31:0] btb_target;

    logic        upd_valid;
    logic        upd_is_jal;
    logic [31:0] upd_pc;
    logic        upd_taken;
    logic [31:0] upd_target;
    logic        upd_mispredict;

    logic [31:0] stat_branches;
    logic [31:0] stat_mispredicts;

    modport master (
        output fetch_pc, upd_valid, upd_is_jal, upd_pc, upd_taken, upd_target, upd_mispredict,
        input  btb_hit, br_pred, btb_target, stat_branches, stat_mispredicts
    );

    modport slave (
        input  fetch_pc, upd_valid, upd_is_jal, upd_pc, upd_taken, upd_target, upd_mispredict,
        output btb_hit, br_pred, btb_target, stat_branches, stat_mispredicts
    );
endinterface

// File: rtl/branch_target_predictor.sv
// Direct-mapped BTB plus bimodal 2-bit counter table, looked up combinationally on the
// fetch PC and trained one edge after each EX resolution. Flop-based so reset clears it.
module branch_target_predictor #(
    parameter int BTB_IDX_BITS = 4,
    parameter int BHT_IDX_BITS = 6
) (
    input logic                        clk,
    input logic                        rst,
    branch_target_predictor_if.slave   bp
);
    localparam int BTB_ENTRIES = 1 << BTB_IDX_BITS;
    localparam int BHT_ENTRIES = 1 << BHT_IDX_BITS;
    localparam int TAG_W       = 32 - BTB_IDX_BITS - 2;

    logic [BTB_ENTRIES-1:0] btb_valid;
    logic [TAG_W-1:0]       btb_tag [BTB_ENTRIES];
    logic [31:0]            btb_tgt [BTB_ENTRIES];
    logic [1:0]             bht_ctr [BHT_ENTRIES];
    logic [31:0]            branches_cnt;
    logic [31:0]            mispredicts_cnt;

    logic [BTB_IDX_BITS-1:0] look_btb_idx;
    logic [BHT_IDX_BITS-1:0] look_bht_idx;
    logic [TAG_W-1:0]        look_tag;
    logic                    look_hit;

    logic [BTB_IDX_BITS-1:0] upd_btb_idx;
    logic [BHT_IDX_BITS-1:0] upd_bht_idx;
    logic [TAG_W-1:0]        upd_tag;
    logic                    upd_taken_eff;
    logic [1:0]              ctr_cur;
    logic [1:0]              ctr_next;

    logic unused_pc_lsbs;
    assign unused_pc_lsbs = ^{bp.fetch_pc[1:0], bp.upd_pc[1:0]};

    // Lookup path: no bypass, so a same-cycle update is only seen from the next cycle.
    assign look_btb_idx = bp.fetch_pc[BTB_IDX_BITS+1:2];
    assign look_bht_idx = bp.fetch_pc[BHT_IDX_BITS+1:2];
    assign look_tag     = bp.fetch_pc[31:BTB_IDX_BITS+2];
    assign look_hit     = btb_valid[look_btb_idx] && (btb_tag[look_btb_idx] == look_tag);

    assign bp.btb_hit          = look_hit;
    assign bp.btb_target       = look_hit ? btb_tgt[look_btb_idx] : 32'd0;
    assign bp.br_pred          = bht_ctr[look_bht_idx][1];
    assign bp.stat_branches    = branches_cnt;
    assign bp.stat_mispredicts = mispredicts_cnt;

    assign upd_btb_idx   = bp.upd_pc[BTB_IDX_BITS+1:2];
    assign upd_bht_idx   = bp.upd_pc[BHT_IDX_BITS+1:2];
    assign upd_tag       = bp.upd_pc[31:BTB_IDX_BITS+2];
    assign upd_taken_eff = bp.upd_is_jal | bp.upd_taken;
    assign ctr_cur       = bht_ctr[upd_bht_idx];

    always_comb begin
        ctr_next = ctr_cur;
        if (bp.upd_is_jal) begin
            ctr_next = 2'd3;
        end else if (bp.upd_taken) begin
            if (ctr_cur != 2'd3) ctr_next = ctr_cur + 2'd1;
        end else begin
            if (ctr_cur != 2'd0) ctr_next = ctr_cur - 2'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            btb_valid <= '0;
            for (int i = 0; i < BTB_ENTRIES; i++) begin
                btb_tag[i] <= '0;
                btb_tgt[i] <= '0;
            end
            for (int i = 0; i < BHT_ENTRIES; i++) begin
                bht_ctr[i] <= 2'b01;
            end
            branches_cnt    <= '0;
            mispredicts_cnt <= '0;
        end else if (bp.upd_valid) begin
            bht_ctr[upd_bht_idx] <= ctr_next;
            // Not-taken branches leave the BTB alone; the counter suppresses redirection.
            if (upd_taken_eff) begin
                btb_valid[upd_btb_idx] <= 1'b1;
                btb_tag[upd_btb_idx]   <= upd_tag;
                btb_tgt[upd_btb_idx]   <= bp.upd_target;
            end
            if (branches_cnt != 32'hFFFF_FFFF) branches_cnt <= branches_cnt + 32'd1;
            if (bp.upd_mispredict && (mispredicts_cnt != 32'hFFFF_FFFF))
                mispredicts_cnt <= mispredicts_cnt + 32'd1;
        end
    end
endmodule

// File: tb/tb_branch_target_predictor.sv
// Scoreboard bench for branch_target_predictor: expected lookups are queued when driven,
// observed lookups queued when sampled, and each scenario task drains and compares them.
module tb_branch_target_predictor;
    logic clk;
    logic rst;

    branch_target_predictor_if bus();

    branch_target_predictor #(.BTB_IDX_BITS(4), .BHT_IDX_BITS(6)) dut (
        .clk (clk),
        .rst (rst),
        .bp  (bus)
    );

    typedef struct {
        logic        hit;
        logic        pred;
        logic [31:0] tgt;
        string       name;
    } look_t;

    look_t exp_q[$];
    look_t obs_q[$];
    int    n_cmp = 0;
    int    n_err = 0;
    int    exp_branches = 0;
    int    exp_mispred  = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1);
    end

    task automatic do_update(input logic [31:0] pc, input logic [31:0] tgt,
                             input logic taken, input logic jal, input logic mis);
        @(negedge clk);
        bus.upd_pc         = pc;
        bus.upd_target     = tgt;
        bus.upd_taken      = taken;
        bus.upd_is_jal     = jal;
        bus.upd_mispredict = mis;
        bus.upd_valid      = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.upd_valid = 1'b0;
        exp_branches++;
        if (mis) exp_mispred++;
    endtask

    task automatic drive_lookup(input logic [31:0] pc, input logic hit, input logic pred,
                                input logic [31:0] tgt, input string name);
        look_t o;
        bus.fetch_pc = pc;
        exp_q.push_back('{hit, pred, tgt, name});
        #1;
        o.hit  = bus.btb_hit;
        o.pred = bus.br_pred;
        o.tgt  = bus.btb_target;
        o.name = name;
        obs_q.push_back(o);
    endtask

    task automatic test_reset();
        look_t e, o;
        rst = 1'b0;
        bus.fetch_pc = 32'd0;
        bus.upd_valid = 1'b0; bus.upd_is_jal = 1'b0; bus.upd_pc = 32'd0;
        bus.upd_taken = 1'b0; bus.upd_target = 32'd0; bus.upd_mispredict = 1'b0;
        #1 rst = 1'b1;
        drive_lookup(32'h0, 1'b0, 1'b0, 32'h0, "reset_async_lookup");
        n_cmp++;
        if (bus.stat_branches !== 32'd0) begin
            n_err++; $display("FAIL reset_stat_branches: got %h want 0", bus.stat_branches);
        end
        n_cmp++;
        if (bus.stat_mispredicts !== 32'd0) begin
            n_err++; $display("FAIL reset_stat_mispredicts: got %h want 0", bus.stat_mispredicts);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 64; i++)
            drive_lookup(32'(i) << 2, 1'b0, 1'b0, 32'h0, $sformatf("reset_sweep_%0d", i));
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); n_cmp++;
            if ({o.hit, o.pred, o.tgt} !== {e.hit, e.pred, e.tgt}) begin
                n_err++;
                $display("FAIL %s: got hit=%b pred=%b tgt=%h want hit=%b pred=%b tgt=%h",
                         e.name, o.hit, o.pred, o.tgt, e.hit, e.pred, e.tgt);
            end
        end
    endtask

    task automatic test_loop_train();
        look_t e, o;
        do_update(32'h40, 32'h20, 1'b1, 1'b0, 1'b0);
        drive_lookup(32'h40, 1'b1, 1'b1, 32'h20, "loop_first_taken");
        do_update(32'h40, 32'h20, 1'b1, 1'b0, 1'b0);
        do_update(32'h40, 32'h20, 1'b1, 1'b0, 1'b0);
        do_update(32'h40, 32'h0,  1'b0, 1'b0, 1'b1);
        drive_lookup(32'h40, 1'b1, 1'b1, 32'h20, "loop_sat3_then_nt");
        do_update(32'h40, 32'h0,  1'b0, 1'b0, 1'b1);
        drive_lookup(32'h40, 1'b1, 1'b0, 32'h20, "loop_second_nt");
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); n_cmp++;
            if ({o.hit, o.pred, o.tgt} !== {e.hit, e.pred, e.tgt}) begin
                n_err++;
                $display("FAIL %s: got hit=%b pred=%b tgt=%h want hit=%b pred=%b tgt=%h",
                         e.name, o.hit, o.pred, o.tgt, e.hit, e.pred, e.tgt);
            end
        end
    endtask

    task automatic test_saturation();
        look_t e, o;
        for (int i = 0; i < 5; i++) begin
            do_update(32'h80, 32'h0, 1'b0, 1'b0, 1'b0);
            drive_lookup(32'h80, 1'b0, 1'b0, 32'h0, $sformatf("sat_nt_%0d", i));
        end
        do_update(32'h80, 32'h84, 1'b1, 1'b0, 1'b0);
        drive_lookup(32'h80, 1'b1, 1'b0, 32'h84, "sat_taken_after_zero");
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); n_cmp++;
            if ({o.hit, o.pred, o.tgt} !== {e.hit, e.pred, e.tgt}) begin
                n_err++;
                $display("FAIL %s: got hit=%b pred=%b tgt=%h want hit=%b pred=%b tgt=%h",
                         e.name, o.hit, o.pred, o.tgt, e.hit, e.pred, e.tgt);
            end
        end
    endtask

    task automatic test_jal();
        look_t e, o;
        do_update(32'h100, 32'h400, 1'b0, 1'b1, 1'b0);
        drive_lookup(32'h100, 1'b1, 1'b1, 32'h400, "jal_forced_taken");
        do_update(32'h100, 32'h0, 1'b0, 1'b0, 1'b0);
        drive_lookup(32'h100, 1'b1, 1'b1, 32'h400, "jal_counter_was_3");
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); n_cmp++;
            if ({o.hit, o.pred, o.tgt} !== {e.hit, e.pred, e.tgt}) begin
                n_err++;
                $display("FAIL %s: got hit=%b pred=%b tgt=%h want hit=%b pred=%b tgt=%h",
                         e.name, o.hit, o.pred, o.tgt, e.hit, e.pred, e.tgt);
            end
        end
    endtask

    task automatic test_conflict();
        look_t e, o;
        do_update(32'h40, 32'h20, 1'b1, 1'b0, 1'b0);
        do_update(32'h80, 32'h90, 1'b1, 1'b0, 1'b0);
        drive_lookup(32'h40,  1'b0, 1'b1, 32'h0,  "conflict_evicted");
        drive_lookup(32'h80,  1'b1, 1'b1, 32'h90, "conflict_new_owner");
        drive_lookup(32'h140, 1'b0, 1'b1, 32'h0,  "alias_bht_shared");
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); n_cmp++;
            if ({o.hit, o.pred, o.tgt} !== {e.hit, e.pred, e.tgt}) begin
                n_err++;
                $display("FAIL %s: got hit=%b pred=%b tgt=%h want hit=%b pred=%b tgt=%h",
                         e.name, o.hit, o.pred, o.tgt, e.hit, e.pred, e.tgt);
            end
        end
    endtask

    task automatic test_same_cycle();
        look_t e, o;
        @(negedge clk);
        bus.upd_pc = 32'h200; bus.upd_target = 32'h300; bus.upd_taken = 1'b1;
        bus.upd_is_jal = 1'b0; bus.upd_mispredict = 1'b0; bus.upd_valid = 1'b1;
        drive_lookup(32'h200, 1'b0, 1'b1, 32'h0, "same_cycle_no_bypass");
        @(posedge clk);
        @(negedge clk);
        bus.upd_valid = 1'b0;
        exp_branches++;
        drive_lookup(32'h200, 1'b1, 1'b1, 32'h300, "same_cycle_next");
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); n_cmp++;
            if ({o.hit, o.pred, o.tgt} !== {e.hit, e.pred, e.tgt}) begin
                n_err++;
                $display("FAIL %s: got hit=%b pred=%b tgt=%h want hit=%b pred=%b tgt=%h",
                         e.name, o.hit, o.pred, o.tgt, e.hit, e.pred, e.tgt);
            end
        end
    endtask

    task automatic test_back_to_back();
        look_t e, o;
        logic        tk [6];
        logic [31:0] tg [6];
        tk = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        tg = '{32'h0, 32'h500, 32'h504, 32'h508, 32'h0, 32'h0};
        @(negedge clk);
        bus.upd_pc = 32'h3C0; bus.upd_is_jal = 1'b0; bus.upd_mispredict = 1'b0;
        for (int i = 0; i < 6; i++) begin
            bus.upd_taken  = tk[i];
            bus.upd_target = tg[i];
            bus.upd_valid  = 1'b1;
            @(negedge clk);
            exp_branches++;
            if (i == 3) begin
                bus.upd_valid = 1'b0;
                drive_lookup(32'h3C0, 1'b1, 1'b1, 32'h508, "b2b_after_takens");
            end
        end
        bus.upd_valid = 1'b0;
        drive_lookup(32'h3C0, 1'b1, 1'b0, 32'h508, "b2b_after_two_nt");
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); n_cmp++;
            if ({o.hit, o.pred, o.tgt} !== {e.hit, e.pred, e.tgt}) begin
                n_err++;
                $display("FAIL %s: got hit=%b pred=%b tgt=%h want hit=%b pred=%b tgt=%h",
                         e.name, o.hit, o.pred, o.tgt, e.hit, e.pred, e.tgt);
            end
        end
    endtask

    task automatic test_stats();
        look_t e, o;
        // An update presented while reset is high must be dropped.
        @(negedge clk);
        bus.upd_pc = 32'h600; bus.upd_target = 32'h700; bus.upd_taken = 1'b1;
        bus.upd_is_jal = 1'b0; bus.upd_mispredict = 1'b1; bus.upd_valid = 1'b1;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        bus.upd_valid = 1'b0;
        exp_branches = 0; exp_mispred = 0;
        drive_lookup(32'h600, 1'b0, 1'b0, 32'h0, "midreset_discarded");
        do_update(32'h600, 32'h700, 1'b1, 1'b0, 1'b1);
        drive_lookup(32'h600, 1'b1, 1'b1, 32'h700, "first_after_reset");
        do_update(32'h600, 32'h700, 1'b1, 1'b0, 1'b0);
        do_update(32'h600, 32'h700, 1'b1, 1'b0, 1'b1);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); n_cmp++;
            if ({o.hit, o.pred, o.tgt} !== {e.hit, e.pred, e.tgt}) begin
                n_err++;
                $display("FAIL %s: got hit=%b pred=%b tgt=%h want hit=%b pred=%b tgt=%h",
                         e.name, o.hit, o.pred, o.tgt, e.hit, e.pred, e.tgt);
            end
        end
        n_cmp++;
        if (bus.stat_branches !== 32'd3) begin
            n_err++; $display("FAIL stat_branches_3: got %0d want 3", bus.stat_branches);
        end
        n_cmp++;
        if (bus.stat_mispredicts !== 32'd2) begin
            n_err++; $display("FAIL stat_mispredicts_2: got %0d want 2", bus.stat_mispredicts);
        end
        @(negedge clk);
        force dut.branches_cnt = 32'hFFFF_FFFF;
        #1 release dut.branches_cnt;
        do_update(32'h604, 32'h0, 1'b0, 1'b0, 1'b0);
        n_cmp++;
        if (bus.stat_branches !== 32'hFFFF_FFFF) begin
            n_err++; $display("FAIL stat_branches_sat: got %h want ffffffff", bus.stat_branches);
        end
        n_cmp++;
        if (bus.stat_mispredicts !== 32'd2) begin
            n_err++; $display("FAIL stat_mispredicts_hold: got %0d want 2", bus.stat_mispredicts);
        end
        @(negedge clk);
        force dut.mispredicts_cnt = 32'hFFFF_FFFF;
        #1 release dut.mispredicts_cnt;
        do_update(32'h604, 32'h0, 1'b0, 1'b0, 1'b1);
        n_cmp++;
        if (bus.stat_mispredicts !== 32'hFFFF_FFFF) begin
            n_err++; $display("FAIL stat_mispredicts_sat: got %h want ffffffff", bus.stat_mispredicts);
        end
    endtask

    initial begin
        test_reset();
        test_loop_train();
        test_saturation();
        test_jal();
        test_conflict();
        test_same_cycle();
        test_back_to_back();
        test_stats();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/branch_target_predictor.md
# branch_target_predictor

Branch predictor and branch target buffer (BTB) that answers the fetch stage's per-cycle prediction query and absorbs branch/jump resolutions from EX. Lookup is combinational on the current fetch PC, so prediction is available in the same cycle the fetch stage selects the next PC. Predictor state is updated one cycle after each EX resolution.

## Interface
Parameters:
- BTB_IDX_BITS, 4: BTB has 2^BTB_IDX_BITS direct-mapped entries, indexed by pc[BTB_IDX_BITS+1:2].
- BHT_IDX_BITS, 6: bimodal table has 2^BHT_IDX_BITS 2-bit counters, indexed by pc[BHT_IDX_BITS+1:2].

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- fetch_pc  input  32  PC currently presented to the icache.
- btb_hit  output  1  valid BTB entry whose tag matches fetch_pc[31:BTB_IDX_BITS+2].
- br_pred  output  1  MSB of the BHT counter for fetch_pc; 1 means predict taken.
- btb_target  output  32  stored target of the matching entry; 0 when btb_hit=0.
- upd_valid  input  1  EX resolved a control-flow instruction this cycle.
- upd_is_jal  input  1  resolved instruction is a JAL (unconditional, fixed target); 0 means conditional branch.
- upd_pc  input  32  PC of the resolved instruction.
- upd_taken  input  1  actual outcome; ignored (treated as 1) when upd_is_jal=1.
- upd_target  input  32  actual taken target.
- upd_mispredict  input  1  EX detected that the fetch direction or target was wrong.
- stat_branches  output  32  count of accepted updates.
- stat_mispredicts  output  32  count of accepted updates with upd_mispredict=1.

## Operation
- Tables are built from flops, not SRAM, so that asynchronous reset can clear them.
- Lookup is purely combinational from fetch_pc and current table state; it has no enable input.
- Accepted update: upd_valid=1 at a rising edge. JALR is never sent on this port, because its target is register-dependent.
- BHT update on a conditional branch: if taken, counter = min(counter+1, 3); otherwise counter = max(counter-1, 0).
- BHT update on JAL: counter is forced to 3.
- BTB update on a taken conditional branch or any JAL: entry[idx] gets valid=1, tag=upd_pc tag, target=upd_target. This overwrites any prior occupant (no replacement policy).
- BTB on a not-taken branch: entry is left unchanged. The BHT counter alone suppresses redirection.
- Statistics: stat_branches increments on every accepted update. stat_mispredicts increments when upd_mispredict=1. Both saturate at 32'hFFFF_FFFF and do not wrap.
- pc[1:0] is ignored for both indexing and tag.

## Timing
- Reset, asynchronous: all BTB valid bits, tags and targets go to 0. All BHT counters go to 2'b01 (weakly not-taken). Both stat counters go to 0.
- Reset is visible on outputs without waiting for a clock edge: btb_hit=0, br_pred=0, btb_target=0.
- Lookup latency is 0 cycles (combinational).
- Update latency: state written at the edge where upd_valid=1. It is visible to a lookup from the next cycle onward.
- Same-cycle lookup and update to the same index: lookup returns the pre-update values. There is no bypass.
- Reset asserted mid-operation: any in-flight update is discarded. The first update accepted after rst deasserts is applied normally.
- Updates back-to-back every cycle to the same index are each applied in order. The counter moves one step per cycle.
- Tag aliasing: a BHT index shared by different PCs shares one counter (no BHT tags). A BTB tag mismatch gives btb_hit=0 whatever the BHT state.

## Test plan
- Reset check: assert rst with no clock edge. Required: btb_hit=0, br_pred=0, btb_target=0 and both stats = 0 immediately. Then sweep fetch_pc over all indices; every lookup shows btb_hit=0 and br_pred=0.
- Train a loop branch: send a taken branch, upd_pc=0x0000_0040, upd_target=0x0000_0020, twice.
  - After the first update: fetch_pc=0x40 gives btb_hit=1, btb_target=0x20, br_pred=1 (counter 2).
  - After the second update: counter 3. A following not-taken update leaves br_pred=1 (counter 2) and btb_hit=1.
- Counter saturation: 5 not-taken updates on 0x80 give counter 0 and br_pred=0. A single taken update then gives counter 1, br_pred=0.
- JAL: upd_is_jal=1, upd_taken=0, upd_pc=0x100, upd_target=0x400. Required: btb_hit=1, br_pred=1, btb_target=0x400.
- Conflict and alias: train 0x40→0x20, then train 0x80 (same BTB index with 16 entries) →0x90.
  - fetch_pc=0x40 gives btb_hit=0.
  - fetch_pc=0x80 gives btb_target=0x90.
- Same-cycle hazard and stats:
  - With fetch_pc=0x200 and an update to 0x200 (taken, target 0x300) in the same cycle, btb_hit=0 that cycle and btb_hit=1 the next.
  - After 3 updates with upd_mispredict pattern 1,0,1: stat_branches=3, stat_mispredicts=2.
  - Forcing stat_branches to 0xFFFF_FFFF and applying one more update leaves it at 0xFFFF_FFFF.
